// File: rtl/hex2nib.sv
// rtl/hex2nib.sv - combinational ASCII hex digit to nibble decoder
//
// Ports:
//   i_byte  [7:0]  ASCII byte to decode
//   o_nib   [3:0]  nibble value, 0 when the byte is not a hex digit
//   o_valid        1 when the byte is '0'-'9', 'a'-'f' or 'A'-'F'

module hex2nib (
    input  logic [7:0] i_byte,
    output logic [3:0] o_nib,
    output logic       o_valid
);

    always_comb begin
        o_nib   = 4'h0;
        o_valid = 1'b1;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_nib = i_byte[3:0];
        end else if ((i_byte >= 8'h61 && i_byte <= 8'h66) ||
                     (i_byte >= 8'h41 && i_byte <= 8'h46)) begin
            // Both letter ranges have 1..6 in the low nibble for a..f.
            o_nib = i_byte[3:0] + 4'd9;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/hex_frame_defs.svh
// rtl/hex_frame_defs.svh - framing constants and parser states shared by the hex word tx/rx ends
//
// Included inside a module body. It provides the ASCII framing bytes of the
// "0x" + 8 hex digits + CR LF line format, the number of digits per word and
// the parser state encoding.

localparam logic [7:0] ASCII_ZERO   = 8'h30;
localparam logic [7:0] ASCII_X      = 8'h78;
localparam logic [7:0] ASCII_CR     = 8'h0D;
localparam logic [7:0] ASCII_LF     = 8'h0A;
localparam int         FRAME_DIGITS = 8;

typedef enum logic [2:0] {
    ST_IDLE,
    ST_ZERO,
    ST_DIGITS,
    ST_WAIT_CR,
    ST_WAIT_LF
} frame_state_e;

// File: rtl/rxdata.sv
// rtl/rxdata.sv - parses "0xHHHHHHHH\r\n" lines from a UART byte stream into 32-bit words
//
// Ports:
//   i_clk            system clock
//   i_reset_n        synchronous active-low reset
//   i_stb            i_byte is valid this cycle
//   i_byte   [7:0]   received ASCII byte
//   o_stb            one-cycle pulse, o_data holds a newly completed word
//   o_data   [31:0]  last completed word, held between frames
//   o_err            one-cycle pulse, malformed frame discarded

module rxdata #(
    parameter bit OPT_STRICT_CRLF = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stb,
    input  logic [7:0]  i_byte,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic        o_err
);

    `include "hex_frame_defs.svh"

    frame_state_e state_q, state_d;
    logic [31:0]  sreg_q, sreg_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [31:0]  data_q, data_d;
    logic         stb_q, stb_d;
    logic         err_q, err_d;

    logic [3:0]   nib;
    logic         nib_valid;
    logic         complete;
    logic         fail;

    hex2nib u_hex2nib (
        .i_byte  (i_byte),
        .o_nib   (nib),
        .o_valid (nib_valid)
    );

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        stb_d    = 1'b0;
        err_d    = 1'b0;
        complete = 1'b0;
        fail     = 1'b0;

        if (i_stb) begin
            case (state_q)
                ST_IDLE: begin
                    // Bytes outside a frame are line noise, not errors.
                    if (i_byte == ASCII_ZERO) state_d = ST_ZERO;
                end
                ST_ZERO: begin
                    if (i_byte == ASCII_X) begin
                        state_d = ST_DIGITS;
                        sreg_d  = 32'h0;
                        cnt_d   = 3'd0;
                    end else begin
                        fail = 1'b1;
                    end
                end
                ST_DIGITS: begin
                    if (nib_valid) begin
                        sreg_d = {sreg_q[27:0], nib};
                        cnt_d  = cnt_q + 3'd1;
                        // The counter wraps to 0 on the last digit; the state
                        // change is what marks the word as full.
                        if (cnt_q == 3'(FRAME_DIGITS - 1)) state_d = ST_WAIT_CR;
                    end else begin
                        fail = 1'b1;
                    end
                end
                ST_WAIT_CR: begin
                    if (i_byte == ASCII_CR) begin
                        state_d = ST_WAIT_LF;
                    end else if (!OPT_STRICT_CRLF && i_byte == ASCII_LF) begin
                        complete = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end
                ST_WAIT_LF: begin
                    if (i_byte == ASCII_LF) complete = 1'b1;
                    else                    fail     = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (complete) begin
            data_d  = sreg_q;
            stb_d   = 1'b1;
            state_d = ST_IDLE;
        end

        // A '0' that breaks a frame may itself start the next one.
        if (fail) begin
            err_d   = 1'b1;
            state_d = (i_byte == ASCII_ZERO) ? ST_ZERO : ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= 32'h0;
            cnt_q   <= 3'd0;
            data_q  <= 32'h0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    assign o_stb  = stb_q;
    assign o_data = data_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_rxdata.sv
// tb/tb_rxdata.sv - scoreboard bench for rxdata, strict and relaxed terminator variants side by side

module tb_rxdata;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_stb = 1'b0;
    logic [7:0]  in_byte = 8'h00;

    logic        stb0, stb1, err0, err1;
    logic [31:0] data0, data1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Index 0: CR LF required. Index 1: bare LF also accepted.
    rxdata #(.OPT_STRICT_CRLF(1'b1)) u_dut_strict (
        .i_clk(clk), .i_reset_n(rst_n), .i_stb(in_stb), .i_byte(in_byte),
        .o_stb(stb0), .o_data(data0), .o_err(err0)
    );

    rxdata #(.OPT_STRICT_CRLF(1'b0)) u_dut_relaxed (
        .i_clk(clk), .i_reset_n(rst_n), .i_stb(in_stb), .i_byte(in_byte),
        .o_stb(stb1), .o_data(data1), .o_err(err1)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        expq [2][$];
    logic [31:0] hold [2];

    // Reference model: the text received since a candidate frame started.
    logic [7:0]  mbuf [2][12];
    int          mlen [2];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
    endfunction

    function automatic int hex_val(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "a" && b <= "f") return int'(b) - 97 + 10;
        return int'(b) - 65 + 10;
    endfunction

    // Whether byte b is acceptable at character position pos of a line.
    function automatic bit char_ok(input int pos, input logic [7:0] b, input bit strict);
        if (pos == 1)              return b == "x";
        if (pos >= 2 && pos <= 9)  return is_hex(b);
        if (pos == 10)             return b == 8'h0D || (!strict && b == 8'h0A);
        return b == 8'h0A;
    endfunction

    task automatic model_byte(input int k, input logic [7:0] b);
        exp_t        e;
        logic [31:0] v;
        int          pos;
        bit          strict;
        strict = (k == 0);
        e.cyc  = cyc + 1;
        if (mlen[k] == 0) begin
            if (b == "0") begin
                mbuf[k][0] = b;
                mlen[k] = 1;
            end
            return;
        end
        pos = mlen[k];
        if (!char_ok(pos, b, strict)) begin
            e.is_err = 1'b1;
            e.data   = 32'h0;
            expq[k].push_back(e);
            mlen[k] = (b == "0") ? 1 : 0;
            return;
        end
        mbuf[k][pos] = b;
        mlen[k] = pos + 1;
        if (pos == 11 || (pos == 10 && b == 8'h0A)) begin
            v = 32'h0;
            for (int i = 2; i <= 9; i++) v = v * 16 + 32'(hex_val(mbuf[k][i]));
            e.is_err = 1'b0;
            e.data   = v;
            expq[k].push_back(e);
            mlen[k] = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_stb  = 1'b1;
        in_byte = b;
        model_byte(0, b);
        model_byte(1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_stb  = 1'b0;
            in_byte = 8'h00;
        end
    endtask

    task automatic send_str(input string s, input int maxgap);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        in_stb = 1'b0;
        for (int k = 0; k < 2; k++) begin
            expq[k].delete();
            mlen[k] = 0;
            hold[k] = 32'h0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        check(data0 == 32'h0 && data1 == 32'h0, "reset_data", data0 | data1, 32'h0);
        check(!stb0 && !stb1, "reset_stb", {30'h0, stb1, stb0}, 32'h0);
        check(!err0 && !err1, "reset_err", {30'h0, err1, err0}, 32'h0);
    endtask

    // Monitor: every output event must match the next expectation and cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                logic        s, er;
                logic [31:0] d;
                exp_t        e;
                s  = (k == 0) ? stb0 : stb1;
                er = (k == 0) ? err0 : err1;
                d  = (k == 0) ? data0 : data1;
                if (s && er) check(1'b0, "stb_and_err", 32'h3, 32'h0);
                if (s || er) begin
                    if (expq[k].size() == 0) begin
                        check(1'b0, "unexpected_event", {30'h0, er, s}, 32'h0);
                    end else begin
                        e = expq[k].pop_front();
                        check(e.cyc == cyc, "event_cycle", 32'(cyc), 32'(e.cyc));
                        check(er == e.is_err, "event_kind_err", {31'h0, er}, {31'h0, e.is_err});
                        if (!e.is_err) begin
                            check(d == e.data, "word_data", d, e.data);
                            hold[k] = e.data;
                        end else begin
                            check(d == hold[k], "data_held_on_err", d, hold[k]);
                        end
                    end
                end else begin
                    if (expq[k].size() != 0 && expq[k][0].cyc <= cyc) begin
                        e = expq[k].pop_front();
                        check(1'b0, "missing_event", 32'h0, e.data);
                    end
                    if (d != hold[k]) check(1'b0, "data_hold", d, hold[k]);
                end
            end
        end
    end

    initial begin
        string       s;
        logic [31:0] w;
        int          pos;
        byte         junk;

        for (int k = 0; k < 2; k++) begin
            mlen[k] = 0;
            hold[k] = 32'h0;
        end
        idle(3);
        do_reset();

        send_str("0x1234abcd\r\n", 0);
        idle(3);
        send_str("0xDEADBEEF\r\n", 3);
        idle(3);
        send_str("0x12\r\n0x00000007\r\n", 0);
        idle(3);
        send_str("zz!Q", 1);
        send_str("0x0000g001\r\n0x00000010\r\n", 0);
        idle(3);
        send_str("0xffffffff\n", 0);
        idle(3);
        send_str("00x00000002\r\n", 0);
        idle(3);

        // Reset in the middle of a frame drops it silently.
        send_str("0x1234", 0);
        idle(2);
        do_reset();
        check(expq[0].size() == 0 && expq[1].size() == 0, "reset_queue_empty",
              32'(expq[0].size() + expq[1].size()), 32'h0);
        send_str("0x00000001\r\n", 0);
        idle(3);

        for (int n = 0; n < 60; n++) begin
            w = $urandom;
            s = $sformatf("0x%08x\r\n", w);
            for (int i = 2; i < 10; i++)
                if (s[i] >= "a" && $urandom_range(1, 0) == 1) s[i] = s[i] - 8'd32;
            if ($urandom_range(5, 0) == 0) s = s.substr(0, 10);
            if ($urandom_range(5, 0) == 0) begin
                pos  = int'($urandom_range(s.len() - 1, 0));
                junk = byte'($urandom_range(126, 32));
                s[pos] = junk;
            end
            if ($urandom_range(3, 0) == 0) send(8'($urandom_range(126, 32)));
            send_str(s, int'($urandom_range(3, 0)) == 0 ? 2 : 0);
        end

        idle(6);
        check(expq[0].size() == 0, "drain_strict", 32'(expq[0].size()), 32'h0);
        check(expq[1].size() == 0, "drain_relaxed", 32'(expq[1].size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
